// File: rtl/fma_pkg.sv
// Shared FMA encodings for the pipeline controller and the datapath it drives.
package fma_pkg;

  localparam logic [1:0] MODE_DP = 2'b11;
  localparam logic [1:0] MODE_SP = 2'b10;
  localparam logic [1:0] MODE_HP = 2'b01;

  localparam logic [1:0] PREC_DP = 2'b11;
  localparam logic [1:0] PREC_SP = 2'b10;
  localparam logic [1:0] PREC_HP = 2'b01;

  typedef enum logic [1:0] {
    OP_MUL = 2'b00,
    OP_SUB = 2'b01,
    OP_ADD = 2'b10,
    OP_FMA = 2'b11
  } fma_op_e;

  // A precision wider than the active datapath mode cannot be executed.
  function automatic logic prec_exceeds_mode(input logic [1:0] prec, input logic [1:0] mode);
    return prec > mode;
  endfunction

endpackage

// File: rtl/fma_stage_slot.sv
// One pipeline stage: valid bit plus {op, precision, lane_en}, loaded on advance,
// emptied when its contents move on with nothing behind, cleared by flush.
module fma_stage_slot #(
  parameter int LANES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adv,
  input  logic             drain,
  input  logic             flush,
  input  logic [1:0]       op_i,
  input  logic [1:0]       prec_i,
  input  logic [LANES-1:0] lane_i,
  output logic             valid_o,
  output logic [1:0]       op_o,
  output logic [1:0]       prec_o,
  output logic [LANES-1:0] lane_o
);

  logic             valid_q, valid_d;
  logic [1:0]       op_q, op_d;
  logic [1:0]       prec_q, prec_d;
  logic [LANES-1:0] lane_q, lane_d;

  always_comb begin
    valid_d = valid_q;
    op_d    = op_q;
    prec_d  = prec_q;
    lane_d  = lane_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (adv) begin
      valid_d = 1'b1;
      op_d    = op_i;
      prec_d  = prec_i;
      lane_d  = lane_i;
    end else if (drain) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      op_q    <= '0;
      prec_q  <= '0;
      lane_q  <= '0;
    end else begin
      valid_q <= valid_d;
      op_q    <= op_d;
      prec_q  <= prec_d;
      lane_q  <= lane_d;
    end
  end

  assign valid_o = valid_q;
  assign op_o    = op_q;
  assign prec_o  = prec_q;
  assign lane_o  = lane_q;

endmodule

// File: rtl/fma_pipe_ctrl.sv
// Control for a STAGES-deep FMA datapath: per-stage enables with bubble collapse,
// mode-switch drain, precision rejection, flush and handshake counters.
module fma_pipe_ctrl
  import fma_pkg::*;
#(
  parameter int STAGES = 4,
  parameter int LANES  = 4,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_mode,
  input  logic [1:0]        in_precision,
  input  logic [1:0]        in_op,
  input  logic [LANES-1:0]  in_lane_en,
  input  logic              flush,
  output logic [STAGES-1:0] stage_en,
  output logic [1:0]        cur_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        out_op,
  output logic [1:0]        out_precision,
  output logic [LANES-1:0]  out_lane_en,
  output logic              err_prec,
  output logic              busy,
  output logic [CNT_W-1:0]  issued_cnt,
  output logic [CNT_W-1:0]  retired_cnt
);

  logic [STAGES-1:0] valid;
  logic [STAGES-1:0] take_out;
  logic [1:0]        op_s   [STAGES];
  logic [1:0]        prec_s [STAGES];
  logic [LANES-1:0]  lane_s [STAGES];

  logic             accept, prec_bad;
  logic [1:0]       cur_mode_q, cur_mode_d;
  logic             err_prec_q, err_prec_d;
  logic [CNT_W-1:0] issued_q, issued_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  assign busy = |valid;

  // Enables resolve from the output stage backwards so a stage may refill in the
  // same cycle it hands its contents on.
  always_comb begin
    int unsigned k;
    stage_en = '0;
    take_out = '0;
    take_out[STAGES-1] = valid[STAGES-1] & out_ready & ~flush;
    for (int unsigned i = 0; i < STAGES - 1; i++) begin
      k = STAGES - 1 - i;
      stage_en[k]   = valid[k-1] & (~valid[k] | take_out[k]) & ~flush;
      take_out[k-1] = stage_en[k];
    end
    in_ready = rst & ~flush & (~valid[0] | take_out[0])
             & ~(busy & (in_mode != cur_mode_q));
    accept      = in_valid & in_ready;
    prec_bad    = accept & prec_exceeds_mode(in_precision, in_mode);
    stage_en[0] = accept & ~prec_bad;
  end

  always_comb begin
    cur_mode_d = accept ? in_mode : cur_mode_q;
    err_prec_d = err_prec_q | prec_bad;
    issued_d   = issued_q;
    retired_d  = retired_q;
    if (stage_en[0])        issued_d  = issued_q + CNT_W'(1);
    if (take_out[STAGES-1]) retired_d = retired_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_mode_q <= MODE_DP;
      err_prec_q <= 1'b0;
      issued_q   <= '0;
      retired_q  <= '0;
    end else begin
      cur_mode_q <= cur_mode_d;
      err_prec_q <= err_prec_d;
      issued_q   <= issued_d;
      retired_q  <= retired_d;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [1:0]       op_in, prec_in;
    logic [LANES-1:0] lane_in;
    if (k == 0) begin : g_head
      assign op_in   = in_op;
      assign prec_in = in_precision;
      assign lane_in = in_lane_en;
    end else begin : g_body
      assign op_in   = op_s[k-1];
      assign prec_in = prec_s[k-1];
      assign lane_in = lane_s[k-1];
    end
    fma_stage_slot #(.LANES(LANES)) u_slot (
      .clk     (clk),
      .rst     (rst),
      .adv     (stage_en[k]),
      .drain   (take_out[k]),
      .flush   (flush),
      .op_i    (op_in),
      .prec_i  (prec_in),
      .lane_i  (lane_in),
      .valid_o (valid[k]),
      .op_o    (op_s[k]),
      .prec_o  (prec_s[k]),
      .lane_o  (lane_s[k])
    );
  end

  assign out_valid     = valid[STAGES-1];
  assign out_op        = op_s[STAGES-1];
  assign out_precision = prec_s[STAGES-1];
  assign out_lane_en   = lane_s[STAGES-1];
  assign cur_mode      = cur_mode_q;
  assign err_prec      = err_prec_q;
  assign issued_cnt    = issued_q;
  assign retired_cnt   = retired_q;

endmodule

// File: tb/tb_fma_pipe_ctrl.sv
// Randomized bench for fma_pipe_ctrl against an in-order queue model with
// presentation time max(accept+STAGES, previous retire+1).
module tb_fma_pipe_ctrl;
  import fma_pkg::*;

  localparam int S  = 4;
  localparam int L  = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready;
  logic [1:0]    in_mode, in_precision, in_op;
  logic [L-1:0]  in_lane_en;
  logic          flush;
  logic [S-1:0]  stage_en;
  logic [1:0]    cur_mode;
  logic          out_valid, out_ready;
  logic [1:0]    out_op, out_precision;
  logic [L-1:0]  out_lane_en;
  logic          err_prec, busy;
  logic [CW-1:0] issued_cnt, retired_cnt;

  always #5 clk = ~clk;

  fma_pipe_ctrl #(.STAGES(S), .LANES(L), .CNT_W(CW)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_mode       (in_mode),
    .in_precision  (in_precision),
    .in_op         (in_op),
    .in_lane_en    (in_lane_en),
    .flush         (flush),
    .stage_en      (stage_en),
    .cur_mode      (cur_mode),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_op        (out_op),
    .out_precision (out_precision),
    .out_lane_en   (out_lane_en),
    .err_prec      (err_prec),
    .busy          (busy),
    .issued_cnt    (issued_cnt),
    .retired_cnt   (retired_cnt)
  );

  typedef struct {
    logic [1:0]   op;
    logic [1:0]   prec;
    logic [L-1:0] lane;
    int           acc;
  } op_t;

  op_t           q[$];
  int            cyc = 0;
  int            last_ret = -100;
  logic [CW-1:0] m_iss, m_ret;
  logic          m_err;
  logic [1:0]    m_mode;
  logic [1:0]    pick_mode = MODE_DP;
  int            n_checks = 0;
  int            n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic m_out_valid();
    int p;
    if (q.size() == 0) return 1'b0;
    p = q[0].acc + S;
    if (last_ret + 1 > p) p = last_ret + 1;
    return cyc >= p;
  endfunction

  task automatic model_reset();
    q.delete();
    last_ret = -100;
    m_iss  = '0;
    m_ret  = '0;
    m_err  = 1'b0;
    m_mode = MODE_DP;
  endtask

  task automatic drive(input logic v, input logic [1:0] md, input logic [1:0] pr,
                       input logic [1:0] op, input logic [L-1:0] ln,
                       input logic ordy, input logic fl);
    logic exp_ir, ov, fire, bad, ret;
    op_t  e;
    @(negedge clk);
    in_valid = v; in_mode = md; in_precision = pr; in_op = op;
    in_lane_en = ln; out_ready = ordy; flush = fl;
    #1;
    ov     = m_out_valid();
    exp_ir = !fl && !(q.size() > 0 && md != m_mode) && (q.size() < S || (ov && ordy));
    fire   = v && exp_ir;
    bad    = fire && (pr > md);
    ret    = ov && ordy;
    check_eq("in_ready", in_ready, exp_ir);
    check_eq("out_valid", out_valid, ov);
    if (ov) begin
      check_eq("out_op", out_op, q[0].op);
      check_eq("out_precision", out_precision, q[0].prec);
      check_eq("out_lane_en", out_lane_en, q[0].lane);
    end
    check_eq("busy", busy, q.size() > 0);
    check_eq("cur_mode", cur_mode, m_mode);
    check_eq("err_prec", err_prec, m_err);
    check_eq("issued_cnt", issued_cnt, m_iss);
    check_eq("retired_cnt", retired_cnt, m_ret);
    check_eq("stage_en0", stage_en[0], fire && !bad);
    @(posedge clk);
    if (fl) begin
      q.delete();
    end else begin
      if (ret) begin
        void'(q.pop_front());
        m_ret++;
        last_ret = cyc;
      end
      if (fire) begin
        m_mode = md;
        if (bad) begin
          m_err = 1'b1;
        end else begin
          e.op = op; e.prec = pr; e.lane = ln; e.acc = cyc;
          q.push_back(e);
          m_iss++;
        end
      end
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, m_mode, 2'b00, OP_MUL, '0, 1'b1, 1'b0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_stage_en", stage_en, '0);
    check_eq("rst_err_prec", err_prec, 1'b0);
    check_eq("rst_issued", issued_cnt, '0);
    check_eq("rst_retired", retired_cnt, '0);
    check_eq("rst_cur_mode", cur_mode, MODE_DP);
    check_eq("rst_in_ready", in_ready, 1'b0);
    check_eq("rst_meta", {out_op, out_precision, out_lane_en}, '0);
    model_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      #1;
      check_eq("rst_hold_in_ready", in_ready, 1'b0);
      check_eq("rst_hold_out_valid", out_valid, 1'b0);
    end
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    #1 rst = 1'b1;
    #1 check_eq("rel_in_ready", in_ready, 1'b1);
    @(posedge clk);
    cyc++;
  endtask

  task automatic rand_phase(input int n, input int vp, input int rp, input int fp, input int bp);
    logic [1:0] pr;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 99) < 4) pick_mode = 2'($urandom_range(1, 3));
      if (pick_mode != 2'b11 && $urandom_range(0, 99) < bp)
        pr = 2'($urandom_range(int'(pick_mode) + 1, 3));
      else
        pr = 2'($urandom_range(0, int'(pick_mode)));
      drive($urandom_range(0, 99) < vp, pick_mode, pr, 2'($urandom),
            L'($urandom), $urandom_range(0, 99) < rp, $urandom_range(0, 99) < fp);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_mode = MODE_DP; in_precision = PREC_DP;
    in_op = OP_FMA; in_lane_en = '0; flush = 1'b0; out_ready = 1'b1;
    model_reset();
    apply_reset();

    // Streaming DP FMA ops at full rate.
    for (int i = 0; i < 10; i++) drive(1'b1, MODE_DP, PREC_DP, OP_FMA, L'(i), 1'b1, 1'b0);
    idle(S + 3);
    #1;
    check_eq("stream_issued", issued_cnt, CW'(10));
    check_eq("stream_retired", retired_cnt, CW'(10));

    // Backpressure: fill and stall the consumer, then release.
    for (int i = 0; i < 6; i++) drive(1'b1, MODE_DP, PREC_SP, OP_ADD, L'(i + 3), 1'b0, 1'b0);
    idle(S + 3);

    // Mode switch must wait for the pipe to drain.
    for (int i = 0; i < 3; i++) drive(1'b1, MODE_DP, PREC_DP, OP_MUL, L'(i), 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) drive(1'b1, MODE_SP, PREC_SP, OP_SUB, 4'hA, 1'b1, 1'b0);
    idle(S + 2);
    #1 check_eq("switch_mode", cur_mode, MODE_SP);

    // Precision wider than mode is accepted but dropped.
    drive(1'b1, MODE_HP, PREC_DP, OP_FMA, 4'hF, 1'b1, 1'b0);
    idle(S + 2);
    #1 check_eq("drop_err_prec", err_prec, 1'b1);

    // Flush with three ops in flight and a simultaneous issue.
    for (int i = 0; i < 3; i++) drive(1'b1, MODE_HP, PREC_HP, OP_ADD, L'(i), 1'b1, 1'b0);
    drive(1'b1, MODE_HP, PREC_HP, OP_ADD, 4'h5, 1'b1, 1'b1);
    idle(S + 2);

    // Reset with the pipeline full and stalled.
    for (int i = 0; i < 6; i++) drive(1'b1, MODE_HP, PREC_HP, OP_MUL, L'(i), 1'b0, 1'b0);
    apply_reset();
    idle(S + 2);

    for (int r = 0; r < 5; r++) begin
      rand_phase(300, 70, 70, 2, 8);
      rand_phase(60, 95, 100, 0, 0);
      apply_reset();
    end
    rand_phase(200, 50, 40, 3, 10);
    idle(S + 4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/fma_pipe_ctrl.md
FMA_PIPE_CTRL -- requirements
Module: fma_pipe_ctrl

Interface
REQ-001 The module SHALL have parameter STAGES, default 4, setting the number of datapath pipeline stages controlled (2..8).
REQ-002 The module SHALL have parameter LANES, default 4, setting the number of SIMD lanes carrying per-lane enables.
REQ-003 The module SHALL have parameter CNT_W, default 32, setting the width of the issue/retire counters.
REQ-004 The module SHALL have a single clock clk; reset rst is asynchronous, active-low.
REQ-005 Ports SHALL be, clock and reset first:
- clk  in  1  clock.
- rst  in  1  async active-low reset.
- in_valid  in  1  issue request.
- in_ready  out  1  issue accepted when in_valid&in_ready.
- in_mode, in_precision, in_op  in  2 each  datapath mode (11 DP, 10 SP, 01 HP), precision, op (11 FMA, 10 add, 01 sub, 00 mul).
- in_lane_en  in  LANES  lanes active for this op.
- flush  in  1  discard all in-flight ops.
- stage_en  out  STAGES  register enable for datapath stage k.
- cur_mode  out  2  mode of ops currently in flight.
- out_valid  out  1  result at last stage valid.
- out_ready  in  1  consumer accepts result.
- out_op, out_precision  out  2 each  metadata of the presented result.
- out_lane_en  out  LANES  lane enables of the presented result.
- err_prec  out  1  sticky: rejected op with precision wider than mode.
- busy  out  1  any stage valid.
- issued_cnt, retired_cnt  out  CNT_W each  handshake counters.

Function
REQ-006 Each stage k SHALL hold a valid bit and metadata {op, precision, lane_en} advancing with the datapath.
REQ-007 Stage k SHALL advance (stage_en[k]=1) iff its input stage holds valid data and (stage k is empty or stage k advances out this cycle); the stage-0 input is the accepted issue.
REQ-008 Last stage advance SHALL be out_valid&out_ready or last stage empty; bubbles SHALL collapse (no global stall).
REQ-009 Latency SHALL be STAGES cycles from accept to out_valid with out_ready held high; sustained throughput 1 op/cycle.
REQ-010 out_valid and all out_* metadata SHALL remain stable while out_valid&~out_ready.
REQ-011 in_ready SHALL be 0 when stage 0 cannot advance, when busy and in_mode!=cur_mode (mode-switch drain), or while flush=1.
REQ-012 cur_mode SHALL load in_mode on any accept; it SHALL hold otherwise.
REQ-013 An op with in_precision>in_mode numerically SHALL be accepted by handshake (in_ready rule unchanged) but dropped (not entered into stage 0) and SHALL set err_prec; err_prec clears only on reset.
REQ-014 flush SHALL clear all valid bits on the next edge; flush has priority over a same-cycle accept and retire (neither counted).
REQ-015 issued_cnt SHALL increment per entered (non-dropped) op; retired_cnt per out_valid&out_ready; both wrap at 2^CNT_W.
REQ-016 busy SHALL be the OR of all stage valid bits.
REQ-017 Ops with in_lane_en=0 SHALL still flow and retire normally.

Reset
REQ-018 On rst low: all valid bits, stage_en, out_valid, err_prec, counters, busy SHALL be 0; cur_mode SHALL be 2'b11; metadata registers SHALL be 0.
REQ-019 in_ready SHALL be 0 during reset and 1 in the first cycle after deassertion.
REQ-020 Reset mid-operation SHALL discard in-flight ops without producing out_valid.

Structure
REQ-021 Mode/precision/op encodings SHALL be constants in the shared fma package, reused by the datapath.
REQ-022 One sub-module, fma_stage_slot (valid + metadata register with advance/flush), SHALL be instantiated STAGES times.

Verification
REQ-023 Stream 10 DP FMA ops, out_ready=1, STAGES=4 -> first out_valid 4 cycles after first accept, 10 consecutive results, issued_cnt=retired_cnt=10.
REQ-024 Fill pipeline, hold out_ready=0 for 6 cycles -> after 4 accepts in_ready=0, out metadata stable; release -> 1 result/cycle, order preserved.
REQ-025 Issue SP op while DP in flight -> in_ready=0 until busy=0, then SP accepted and cur_mode=2'b10.
REQ-026 Issue mode=01, precision=11 -> accepted, nothing retires, err_prec=1, issued_cnt unchanged.
REQ-027 Flush with 3 ops in flight plus simultaneous issue -> busy=0 next cycle, no out_valid, counters unchanged.
REQ-028 Assert rst with pipeline full -> all outputs to reset values immediately; after release in_ready=1, no stale results.
